// File: rtl/bit_region_bbox_detector.sv
// -----------------------------------------------------------------------------
// bit_region_bbox_detector
//
// Purpose:
//   Sits after the binary erosion stage. For each frame it accumulates the
//   bounding box and the number of set pixels inside the active window. At
//   frame end it latches the results for downstream tracking/ROI logic. The
//   pixel stream is re-emitted with one clock of latency. When OVERLAY_EN is
//   set, the border of the previously latched box is ORed into that stream.
//
// Ports:
//   clk               pixel clock
//   rst               asynchronous, active-high reset
//   per_frame_vsync   frame valid (high for the whole frame)
//   per_frame_href    line valid
//   per_img_Bit       binary pixel, 1 = object
//   post_frame_vsync  per_frame_vsync delayed 1 clk
//   post_frame_href   per_frame_href delayed 1 clk
//   post_img_Bit      pixel delayed 1 clk with overlay, 0 outside href
//   bbox_valid        one-cycle pulse when new results are latched
//   bbox_empty        latched frame had no counted pixel
//   bbox_x_min/x_max  latched column bounds
//   bbox_y_min/y_max  latched row bounds
//   bbox_pix_cnt      latched set-pixel count, saturating at 20'hFFFFF
// -----------------------------------------------------------------------------
module bit_region_bbox_detector #(
  parameter logic [10:0] IMG_HDISP  = 11'd640,
  parameter logic [10:0] IMG_VDISP  = 11'd480,
  parameter logic        OVERLAY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_img_Bit,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_img_Bit,
  output logic        bbox_valid,
  output logic        bbox_empty,
  output logic [10:0] bbox_x_min,
  output logic [10:0] bbox_x_max,
  output logic [10:0] bbox_y_min,
  output logic [10:0] bbox_y_max,
  output logic [19:0] bbox_pix_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic        vsync_r, href_r, armed_r;
  logic [10:0] x_cnt_r, y_cnt_r;
  logic [10:0] acc_x_min_r, acc_x_max_r, acc_y_min_r, acc_y_max_r;
  logic [19:0] acc_cnt_r;
  logic        acc_any_r;
  logic        clear_s, latch_s, count_s;
  logic        vsync_rise_s, vsync_fall_s, href_fall_s;
  logic        x_edge_s, y_edge_s, x_in_s, y_in_s, border_s;

  // armed_r only rises once vsync has been seen low after reset, so a frame
  // already running when rst drops cannot look like a fresh rising edge.
  assign vsync_rise_s = per_frame_vsync & ~vsync_r & armed_r;
  assign vsync_fall_s = ~per_frame_vsync & vsync_r;
  assign href_fall_s  = ~per_frame_href & href_r;

  assign count_s = (state_r == ACTIVE) & per_frame_href & per_frame_vsync &
                   per_img_Bit & (x_cnt_r < IMG_HDISP) & (y_cnt_r < IMG_VDISP);

  // Border test against the box currently on the outputs (previous frame).
  assign x_edge_s = (x_cnt_r == bbox_x_min) | (x_cnt_r == bbox_x_max);
  assign y_edge_s = (y_cnt_r == bbox_y_min) | (y_cnt_r == bbox_y_max);
  assign x_in_s   = (x_cnt_r >= bbox_x_min) & (x_cnt_r <= bbox_x_max);
  assign y_in_s   = (y_cnt_r >= bbox_y_min) & (y_cnt_r <= bbox_y_max);
  assign border_s = ~bbox_empty & ((x_edge_s & y_in_s) | (y_edge_s & x_in_s));

  assign post_frame_vsync = vsync_r;
  assign post_frame_href  = href_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (vsync_rise_s) state_nxt_s = ACTIVE;
        else              state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (vsync_fall_s) state_nxt_s = IDLE;
        else              state_nxt_s = ACTIVE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM control outputs: accumulator clear on frame start, latch on frame end.
  always_comb begin
    clear_s = 1'b0;
    latch_s = 1'b0;
    case (state_r)
      IDLE:    clear_s = vsync_rise_s;
      ACTIVE:  latch_s = vsync_fall_s;
      default: begin
        clear_s = 1'b0;
        latch_s = 1'b0;
      end
    endcase
  end

  // Sync history, arming flag and the delayed/overlaid pixel stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_r      <= 1'b0;
      href_r       <= 1'b0;
      armed_r      <= 1'b0;
      post_img_Bit <= 1'b0;
    end else begin
      vsync_r      <= per_frame_vsync;
      href_r       <= per_frame_href;
      armed_r      <= armed_r | ~per_frame_vsync;
      post_img_Bit <= per_frame_href & (per_img_Bit | (OVERLAY_EN & border_s));
    end
  end

  // Pixel coordinate counters, both saturating at 11'h7FF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt_r <= 11'd0;
      y_cnt_r <= 11'd0;
    end else begin
      if (!per_frame_href)         x_cnt_r <= 11'd0;
      else if (x_cnt_r != 11'h7FF) x_cnt_r <= x_cnt_r + 11'd1;
      else                         x_cnt_r <= x_cnt_r;

      if (per_frame_vsync && !vsync_r)           y_cnt_r <= 11'd0;
      else if (href_fall_s && y_cnt_r != 11'h7FF) y_cnt_r <= y_cnt_r + 11'd1;
      else                                        y_cnt_r <= y_cnt_r;
    end
  end

  // Per-frame accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x_min_r <= 11'd0;
      acc_x_max_r <= 11'd0;
      acc_y_min_r <= 11'd0;
      acc_y_max_r <= 11'd0;
      acc_cnt_r   <= 20'd0;
      acc_any_r   <= 1'b0;
    end else if (clear_s) begin
      acc_x_min_r <= 11'h7FF;
      acc_x_max_r <= 11'd0;
      acc_y_min_r <= 11'h7FF;
      acc_y_max_r <= 11'd0;
      acc_cnt_r   <= 20'd0;
      acc_any_r   <= 1'b0;
    end else if (count_s) begin
      if (x_cnt_r < acc_x_min_r) acc_x_min_r <= x_cnt_r;
      if (x_cnt_r > acc_x_max_r) acc_x_max_r <= x_cnt_r;
      if (y_cnt_r < acc_y_min_r) acc_y_min_r <= y_cnt_r;
      if (y_cnt_r > acc_y_max_r) acc_y_max_r <= y_cnt_r;
      if (acc_cnt_r != 20'hFFFFF) acc_cnt_r <= acc_cnt_r + 20'd1;
      acc_any_r <= 1'b1;
    end
  end

  // Result latch at frame end; coordinates read 0 when nothing was counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bbox_valid   <= 1'b0;
      bbox_empty   <= 1'b1;
      bbox_x_min   <= 11'd0;
      bbox_x_max   <= 11'd0;
      bbox_y_min   <= 11'd0;
      bbox_y_max   <= 11'd0;
      bbox_pix_cnt <= 20'd0;
    end else begin
      bbox_valid <= latch_s;
      if (latch_s) begin
        bbox_empty   <= ~acc_any_r;
        bbox_x_min   <= acc_any_r ? acc_x_min_r : 11'd0;
        bbox_x_max   <= acc_any_r ? acc_x_max_r : 11'd0;
        bbox_y_min   <= acc_any_r ? acc_y_min_r : 11'd0;
        bbox_y_max   <= acc_any_r ? acc_y_max_r : 11'd0;
        bbox_pix_cnt <= acc_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_bit_region_bbox_detector.sv
// -----------------------------------------------------------------------------
// tb_bit_region_bbox_detector
//
// Directed bench for bit_region_bbox_detector with an 8x6 active window.
// Frames are built from a small image table; each frame is followed by a
// check of the latched box against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bit_region_bbox_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs, hs, pb;
  logic        post_frame_vsync, post_frame_href, post_img_Bit;
  logic        bbox_valid, bbox_empty;
  logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic [19:0] bbox_pix_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic img [0:7][0:15];
  bit   chk_post;
  int   ov_ones;
  int   rst_line;

  bit_region_bbox_detector #(
    .IMG_HDISP (11'd8),
    .IMG_VDISP (11'd6),
    .OVERLAY_EN(1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .per_frame_vsync (vs),
    .per_frame_href  (hs),
    .per_img_Bit     (pb),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href (post_frame_href),
    .post_img_Bit    (post_img_Bit),
    .bbox_valid      (bbox_valid),
    .bbox_empty      (bbox_empty),
    .bbox_x_min      (bbox_x_min),
    .bbox_x_max      (bbox_x_max),
    .bbox_y_min      (bbox_y_min),
    .bbox_y_max      (bbox_y_max),
    .bbox_pix_cnt    (bbox_pix_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, then look at outputs 1 time unit after the edge.
  task automatic step(input logic v, input logic h, input logic b);
    vs = v; hs = h; pb = b;
    @(posedge clk);
    #1;
  endtask

  // Border of the box x 2..5, y 1..4 (12 pixels).
  function automatic logic on_border(input int x, input int y);
    return (((x == 2) || (x == 5)) && (y >= 1) && (y <= 4)) ||
           (((y == 1) || (y == 4)) && (x >= 2) && (x <= 5));
  endfunction

  task automatic clear_img();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 16; x++)
        img[y][x] = 1'b0;
  endtask

  // One frame with 2-cycle href gaps; returns just after the latch edge.
  task automatic run_frame(input int nlines, input int width);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int y = 0; y < nlines; y++) begin
      if (y == rst_line) begin
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bbox_valid}, 32'd0);
        chk("rst_empty", {31'd0, bbox_empty}, 32'd1);
        chk("rst_xmax", {21'd0, bbox_x_max}, 32'd0);
        chk("rst_ymax", {21'd0, bbox_y_max}, 32'd0);
        chk("rst_cnt", {12'd0, bbox_pix_cnt}, 32'd0);
        chk("rst_post_vs", {31'd0, post_frame_vsync}, 32'd0);
        #1;
        rst = 1'b0;
      end
      for (int x = 0; x < width; x++) begin
        step(1'b1, 1'b1, img[y][x]);
        if (y == 0 && x == 0) begin
          chk("post_vs", {31'd0, post_frame_vsync}, 32'd1);
          chk("post_href", {31'd0, post_frame_href}, 32'd1);
        end
        if (chk_post) begin
          chk("ovl_pix", {31'd0, post_img_Bit}, {31'd0, img[y][x] | on_border(x, y)});
          if (post_img_Bit) ov_ones++;
        end
      end
      for (int g = 0; g < 2; g++) begin
        step(1'b1, 1'b0, 1'b0);
        if (y == 0 && g == 0) chk("post_href_gap", {31'd0, post_frame_href}, 32'd0);
        if (chk_post) chk("ovl_gap", {31'd0, post_img_Bit}, 32'd0);
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_latch(input string tag, input int x0, input int x1, input int y0,
                           input int y1, input int c, input int e);
    chk({tag, "_valid"}, {31'd0, bbox_valid}, 32'd1);
    chk({tag, "_xmin"}, {21'd0, bbox_x_min}, x0);
    chk({tag, "_xmax"}, {21'd0, bbox_x_max}, x1);
    chk({tag, "_ymin"}, {21'd0, bbox_y_min}, y0);
    chk({tag, "_ymax"}, {21'd0, bbox_y_max}, y1);
    chk({tag, "_cnt"}, {12'd0, bbox_pix_cnt}, c);
    chk({tag, "_empty"}, {31'd0, bbox_empty}, e);
    step(1'b0, 1'b0, 1'b0);
    chk({tag, "_valid_drop"}, {31'd0, bbox_valid}, 32'd0);
    chk({tag, "_cnt_hold"}, {12'd0, bbox_pix_cnt}, c);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b0; hs = 1'b0; pb = 1'b0;
    chk_post = 1'b0; ov_ones = 0; rst_line = -1;
    clear_img();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, bbox_valid}, 32'd0);
    chk("reset_empty", {31'd0, bbox_empty}, 32'd1);
    chk("reset_xmin", {21'd0, bbox_x_min}, 32'd0);
    chk("reset_cnt", {12'd0, bbox_pix_cnt}, 32'd0);
    chk("reset_post", {31'd0, post_img_Bit}, 32'd0);
    rst = 1'b0;

    // Single pixel at (3,2).
    img[2][3] = 1'b1;
    run_frame(6, 8);
    chk_latch("single", 3, 3, 2, 2, 1, 0);

    // All-zero frame.
    clear_img();
    run_frame(6, 8);
    chk_latch("zero", 0, 0, 0, 0, 0, 1);

    // Box corners at (2,1) and (5,4).
    img[1][2] = 1'b1;
    img[4][5] = 1'b1;
    run_frame(6, 8);
    chk_latch("box", 2, 5, 1, 4, 2, 0);

    // All-zero frame shows the previous box border on post_img_Bit.
    clear_img();
    chk_post = 1'b1;
    ov_ones = 0;
    run_frame(6, 8);
    chk_post = 1'b0;
    chk("ovl_count", ov_ones, 32'd12);
    chk_latch("ovl_zero", 0, 0, 0, 0, 0, 1);

    // All-ones frame.
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = 1'b1;
    run_frame(6, 8);
    chk_latch("ones", 0, 7, 0, 5, 48, 0);

    // Reset in the middle of an all-ones frame: no latch for that frame.
    rst_line = 2;
    run_frame(6, 8);
    rst_line = -1;
    chk("rstf_valid", {31'd0, bbox_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("rstf_valid2", {31'd0, bbox_valid}, 32'd0);
    chk("rstf_empty", {31'd0, bbox_empty}, 32'd1);

    // Next full frame latches normally.
    clear_img();
    img[2][3] = 1'b1;
    run_frame(6, 8);
    chk_latch("after_rst", 3, 3, 2, 2, 1, 0);

    // Ones only outside the window: x=8,9 and line 6.
    clear_img();
    for (int y = 0; y < 6; y++) begin
      img[y][8] = 1'b1;
      img[y][9] = 1'b1;
    end
    for (int x = 0; x < 10; x++) img[6][x] = 1'b1;
    run_frame(7, 10);
    chk_latch("ignored", 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
